// File: rtl/cnt_sched.sv
// Round-robin scheduler time-sharing one cycle counter among NREQ requesters.
// Optional: define CNT_SCHED_ABORT_EN to abort a run when its REQ drops mid-run.
module cnt_sched #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*CNT_W-1:0] LEN,
  output logic [NREQ-1:0]       GNT,
  output logic [NREQ-1:0]       DONE,
  output logic [CNT_W-1:0]      CNT,
  output logic                  BUSY
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [PW-1:0]     ptr_q, ptr_d;

  logic [CNT_W-1:0]  len_arr [NREQ];
  logic              found;
  logic [PW-1:0]     pick;
  logic [PW-1:0]     idx;
  logic [CNT_W-1:0]  pick_len;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      len_arr[i] = LEN[i*CNT_W +: CNT_W];
    end
  end

  // Search starts just past the last granted requester and wraps at NREQ.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = ptr_q;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = PW'((32'(ptr_q) + i) % NREQ);
      if (!found && REQ[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    pick_len = len_arr[pick];
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d     = S_RUN;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          cnt_d       = '0;
          len_d       = (pick_len == '0) ? CNT_W'(1) : pick_len;
          ptr_d       = pick;
        end
      end
      S_RUN: begin
`ifdef CNT_SCHED_ABORT_EN
        if (!REQ[ptr_q]) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end else
`endif
        if (cnt_q == len_q - 1'b1) begin
          state_d = S_FIN;
          gnt_d   = '0;
          cnt_d   = '0;
          done_d  = gnt_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ptr_q   <= PW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
    end
  end

  assign GNT  = gnt_q;
  assign DONE = done_q;
  assign CNT  = cnt_q;
  assign BUSY = (state_q != S_IDLE);

endmodule
